mips_multicycle_ctrl: RTL and testbench



---
 rtl/mips_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control unit for the 16-bit MIPS core: fetches instructions over a
// req/ack port, decodes them and sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [3:0]  ALUop,
    output logic        ALUsrc,
    output logic [15:0] im,
    input  logic [15:0] alu_result,
    output logic [2:0]  ra1,
    output logic [2:0]  ra2,
    output logic [2:0]  wa,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [15:0] pc,
    output logic [15:0] retired,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_HALT, C_ILL
    } iclass_t;

    state_t      state_q, state_d;
    iclass_t     class_q, class_d;
    logic        run_q;
    logic [15:0] pc_q, pc_d;
    logic [15:0] retired_q, retired_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  aluop_q, aluop_d;
    logic        alusrc_q, alusrc_d;
    logic [15:0] im_q, im_d;
    logic [2:0]  ra1_q, ra1_d;
    logic [2:0]  ra2_q, ra2_d;
    logic [2:0]  wa_q, wa_d;
    logic        illegal_q, illegal_d;

    iclass_t     dec_class;
    logic [3:0]  dec_aluop;
    logic        dec_alusrc;
    logic [15:0] dec_im;
    logic [2:0]  dec_wa;
    logic [15:0] ir_sext;

    assign ir_sext = {{10{ir_q[5]}}, ir_q[5:0]};

    // Instruction decode from the latched IR; consumed on the DECODE -> EXEC edge.
    always_comb begin
        dec_class  = C_ILL;
        dec_aluop  = 4'b0000;
        dec_alusrc = 1'b0;
        dec_im     = 16'h0000;
        dec_wa     = 3'd0;
        case (ir_q[15:12])
            4'b0000: begin
                case (ir_q[2:0])
                    3'b000, 3'b001, 3'b110, 3'b111: begin
                        dec_class = C_RTYPE;
                        dec_aluop = {1'b0, ir_q[2:0]};
                        dec_wa    = ir_q[5:3];
                    end
                    default: dec_class = C_ILL;
                endcase
            end
            4'b0010: begin
                dec_class  = C_LW;
                dec_aluop  = 4'b0010;
                dec_alusrc = 1'b1;
                dec_im     = ir_sext;
                dec_wa     = ir_q[8:6];
            end
            4'b0011: begin
                dec_class  = C_SW;
                dec_aluop  = 4'b0011;
                dec_alusrc = 1'b1;
                dec_im     = ir_sext;
            end
            4'b0100: begin
                dec_class  = C_ADDI;
                dec_aluop  = 4'b0100;
                dec_alusrc = 1'b1;
                dec_im     = ir_sext;
                dec_wa     = ir_q[8:6];
            end
            4'b0101: begin
                dec_class = C_BEQ;
                dec_aluop = 4'b0001;
                dec_im    = ir_sext;
            end
            4'b1111: dec_class = C_HALT;
            default: dec_class = C_ILL;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        ir_d      = ir_q;
        aluop_d   = aluop_q;
        alusrc_d  = alusrc_q;
        im_d      = im_q;
        ra1_d     = ra1_q;
        ra2_d     = ra2_q;
        wa_d      = wa_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (run_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                class_d  = dec_class;
                aluop_d  = dec_aluop;
                alusrc_d = dec_alusrc;
                im_d     = dec_im;
                ra1_d    = ir_q[11:9];
                ra2_d    = ir_q[8:6];
                wa_d     = dec_wa;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                case (class_q)
                    C_RTYPE, C_ADDI: state_d = S_WB;
                    C_LW, C_SW:      state_d = S_MEM;
                    C_BEQ: begin
                        // pc already points past the beq, so the offset is relative to pc+1
                        if (alu_result == 16'h0000) begin
                            pc_d = pc_q + im_q;
                        end
                        retired_d = retired_q + 16'd1;
                        state_d   = S_FETCH;
                    end
                    C_HALT: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (class_q == C_SW) begin
                        retired_d = retired_q + 16'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retired_d = retired_q + 16'd1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // run_q keeps the fetch request low for the first cycle after a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            class_q   <= C_RTYPE;
            run_q     <= 1'b0;
            pc_q      <= 16'h0000;
            retired_q <= 16'h0000;
            ir_q      <= 16'h0000;
            aluop_q   <= 4'b0000;
            alusrc_q  <= 1'b0;
            im_q      <= 16'h0000;
            ra1_q     <= 3'd0;
            ra2_q     <= 3'd0;
            wa_q      <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            ir_q      <= ir_d;
            aluop_q   <= aluop_d;
            alusrc_q  <= alusrc_d;
            im_q      <= im_d;
            ra1_q     <= ra1_d;
            ra2_q     <= ra2_d;
            wa_q      <= wa_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_addr = pc_q;
    assign imem_req  = (state_q == S_FETCH) && run_q;
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = (state_q == S_MEM) && (class_q == C_SW);
    assign reg_we    = (state_q == S_WB) && (wa_q != 3'd0);
    assign wb_sel    = (state_q == S_WB) && (class_q == C_LW);
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign ALUop     = aluop_q;
    assign ALUsrc    = alusrc_q;
    assign im        = im_q;
    assign ra1       = ra1_q;
    assign ra2       = ra2_q;
    assign wa        = wa_q;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: table of instruction records run through a
// req/ack memory model, with expected records queued and popped on completion.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [3:0]  ALUop;
    logic        ALUsrc;
    logic [15:0] im;
    logic [15:0] alu_result = 16'h0000;
    logic [2:0]  ra1, ra2, wa;
    logic        reg_we, wb_sel, dmem_req, dmem_we;
    logic        dmem_ack = 1'b0;
    logic [15:0] pc, retired;
    logic        halted, illegal;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ALUop(ALUop), .ALUsrc(ALUsrc), .im(im), .alu_result(alu_result),
        .ra1(ra1), .ra2(ra2), .wa(wa), .reg_we(reg_we), .wb_sel(wb_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc(pc), .retired(retired), .halted(halted), .illegal(illegal)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] alu;
        int          fw;
        int          dw;
        logic [3:0]  aluop;
        logic        alusrc;
        logic [15:0] imm;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [2:0]  w;
        int          cyc;
        int          we_at;
        int          we_n;
        logic        wbs;
        int          dreq;
        int          dwe;
        logic [15:0] pcv;
        logic [15:0] ret;
        logic        hlt;
        logic        ill;
        bit          rst_b;
    } vec_t;

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t vecs[14];
    vec_t sb_q[$];

    function automatic vec_t mkv(logic [15:0] instr, logic [15:0] alu, int fw, int dw,
                                 logic [3:0] aluop, logic alusrc, logic [15:0] imm,
                                 logic [2:0] r1, logic [2:0] r2, logic [2:0] w,
                                 int cyc, int we_at, logic wbs, int dreq, int dwe,
                                 logic [15:0] pcv, logic [15:0] ret, logic hlt, logic ill, bit rst_b);
        vec_t v;
        v.instr = instr; v.alu = alu; v.fw = fw; v.dw = dw;
        v.aluop = aluop; v.alusrc = alusrc; v.imm = imm;
        v.r1 = r1; v.r2 = r2; v.w = w;
        v.cyc = cyc; v.we_at = we_at; v.we_n = (we_at != 0) ? 1 : 0; v.wbs = wbs;
        v.dreq = dreq; v.dwe = dwe; v.pcv = pcv; v.ret = ret;
        v.hlt = hlt; v.ill = ill; v.rst_b = rst_b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_alu", {ALUop, ALUsrc, im}, 0);
        chk("rst_regs", {ra1, ra2, wa, reg_we, wb_sel}, 0);
        chk("rst_pc_ret", {pc, retired}, 0);
        chk("rst_flags", {halted, illegal, imem_addr}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_imem_req", imem_req, 1);
        chk("rel_imem_addr", imem_addr, 0);
    endtask

    // Runs one instruction from its first FETCH cycle until the next FETCH or HALT.
    task automatic run_vec(input vec_t v, output vec_t o);
        int cyc = 0;
        int fw = 0;
        int dw = 0;
        bit fetched = 0;
        bit done = 0;
        o = v;
        o.we_at = 0; o.we_n = 0; o.wbs = 1'b0; o.dreq = 0; o.dwe = 0;
        alu_result = v.alu;
        while (!done) begin
            if (fetched && (imem_req || halted)) begin
                done = 1;
            end else if (cyc >= 60) begin
                chk("instr_timeout", cyc, 0);
                done = 1;
            end else begin
                cyc++;
                if (reg_we) begin
                    o.we_at = cyc;
                    o.we_n++;
                end
                o.wbs = o.wbs | wb_sel;
                if (dmem_req) begin
                    o.dreq++;
                    if (dmem_we) o.dwe++;
                    dmem_ack = (dw == v.dw);
                    dw++;
                end else begin
                    dmem_ack = 1'b0;
                end
                if (imem_req) begin
                    imem_rdata = v.instr;
                    imem_ack   = (fw == v.fw);
                    if (imem_ack) fetched = 1;
                    fw++;
                end else begin
                    imem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        o.cyc = cyc; o.aluop = ALUop; o.alusrc = ALUsrc; o.imm = im;
        o.r1 = ra1; o.r2 = ra2; o.w = wa; o.pcv = pc; o.ret = retired;
        o.hlt = halted; o.ill = illegal;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t o, e;
        logic [15:0] cur_pc;
        //              instr     alu      fw dw op  src imm       r1 r2 w  cyc we wbs dr dwe pc       ret    h  i  rst
        vecs[0]  = mkv(16'h52BE, 16'h0000, 0, 0, 1, 0, 16'hFFFE, 1, 2, 0, 3, 0, 0, 0, 0, 16'hFFFF, 16'd1, 0, 0, 1);
        vecs[1]  = mkv(16'h0298, 16'h1234, 0, 0, 0, 0, 16'h0000, 1, 2, 3, 4, 4, 0, 0, 0, 16'h0000, 16'd2, 0, 0, 0);
        vecs[2]  = mkv(16'h42BF, 16'h0005, 2, 0, 4, 1, 16'hFFFF, 1, 2, 2, 6, 6, 0, 0, 0, 16'h0001, 16'd3, 0, 0, 0);
        vecs[3]  = mkv(16'h2284, 16'h0040, 0, 3, 2, 1, 16'h0004, 1, 2, 2, 8, 8, 1, 4, 0, 16'h0002, 16'd4, 0, 0, 0);
        vecs[4]  = mkv(16'h3284, 16'h0040, 0, 1, 3, 1, 16'h0004, 1, 2, 0, 5, 0, 0, 2, 2, 16'h0003, 16'd5, 0, 0, 0);
        vecs[5]  = mkv(16'h0281, 16'h0000, 0, 0, 1, 0, 16'h0000, 1, 2, 0, 4, 0, 0, 0, 0, 16'h0004, 16'd6, 0, 0, 0);
        vecs[6]  = mkv(16'h0D7E, 16'h0000, 1, 0, 6, 0, 16'h0000, 6, 5, 7, 5, 5, 0, 0, 0, 16'h0005, 16'd7, 0, 0, 0);
        vecs[7]  = mkv(16'h52BE, 16'h0001, 0, 0, 1, 0, 16'hFFFE, 1, 2, 0, 3, 0, 0, 0, 0, 16'h0006, 16'd8, 0, 0, 0);
        vecs[8]  = mkv(16'h04CF, 16'h0000, 0, 0, 7, 0, 16'h0000, 2, 3, 1, 4, 4, 0, 0, 0, 16'h0007, 16'd9, 0, 0, 0);
        vecs[9]  = mkv(16'h52BD, 16'h0000, 0, 0, 1, 0, 16'hFFFD, 1, 2, 0, 3, 0, 0, 0, 0, 16'h0005, 16'd10, 0, 0, 0);
        vecs[10] = mkv(16'h52BE, 16'h0000, 0, 0, 1, 0, 16'hFFFE, 1, 2, 0, 3, 0, 0, 0, 0, 16'h0004, 16'd11, 0, 0, 0);
        vecs[11] = mkv(16'hF000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 3, 0, 0, 0, 0, 16'h0005, 16'd11, 1, 0, 0);
        vecs[12] = mkv(16'h9000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 3, 0, 0, 0, 0, 16'h0001, 16'd0, 1, 1, 1);
        vecs[13] = mkv(16'h0002, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 3, 0, 0, 0, 0, 16'h0001, 16'd0, 1, 1, 1);

        cur_pc = 16'h0000;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst_b) begin
                do_reset();
                cur_pc = 16'h0000;
            end
            chk($sformatf("v%0d.imem_addr", i), imem_addr, cur_pc);
            sb_q.push_back(vecs[i]);
            run_vec(vecs[i], o);
            e = sb_q.pop_front();
            $display("vec %0d instr %04h cycles %0d pc %04h retired %0d halted %0d illegal %0d",
                     i, e.instr, o.cyc, o.pcv, o.ret, o.hlt, o.ill);
            chk($sformatf("v%0d.ALUop", i), o.aluop, e.aluop);
            chk($sformatf("v%0d.ALUsrc", i), o.alusrc, e.alusrc);
            chk($sformatf("v%0d.im", i), o.imm, e.imm);
            chk($sformatf("v%0d.ra1", i), o.r1, e.r1);
            chk($sformatf("v%0d.ra2", i), o.r2, e.r2);
            chk($sformatf("v%0d.wa", i), o.w, e.w);
            chk($sformatf("v%0d.cycles", i), o.cyc, e.cyc);
            chk($sformatf("v%0d.reg_we_cycle", i), o.we_at, e.we_at);
            chk($sformatf("v%0d.reg_we_pulses", i), o.we_n, e.we_n);
            chk($sformatf("v%0d.wb_sel", i), o.wbs, e.wbs);
            chk($sformatf("v%0d.dmem_req_cycles", i), o.dreq, e.dreq);
            chk($sformatf("v%0d.dmem_we_cycles", i), o.dwe, e.dwe);
            chk($sformatf("v%0d.pc", i), o.pcv, e.pcv);
            chk($sformatf("v%0d.retired", i), o.ret, e.ret);
            chk($sformatf("v%0d.halted", i), o.hlt, e.hlt);
            chk($sformatf("v%0d.illegal", i), o.ill, e.ill);
            cur_pc = e.pcv;
            if (e.hlt) begin
                // HALT must ignore acks and never request again
                imem_ack = 1'b1; dmem_ack = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d.halt_reqs", i), {imem_req, dmem_req}, 0);
                    chk($sformatf("v%0d.halt_hold", i), {halted, retired}, {e.hlt, e.ret});
                end
                imem_ack = 1'b0; dmem_ack = 1'b0;
            end
        end

        // Reset during a sw data handshake, coinciding with dmem_ack: reset wins.
        do_reset();
        imem_rdata = 16'h3284;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int k = 0; k < 10 && !dmem_req; k++) @(negedge clk);
        chk("midrst_in_mem", {dmem_req, dmem_we}, 2'b11);
        rst      = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("midrst_reqs", {imem_req, dmem_req, dmem_we}, 0);
        chk("midrst_pc_ret", {pc, retired}, 0);
        chk("midrst_alu", {ALUop, ALUsrc, im}, 0);
        rst      = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("midrst_refetch", {imem_req, imem_addr}, {1'b1, 16'h0000});
        chk("midrst_retired", retired, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
